// File: rtl/dram_arbiter_mc.sv
// Round-robin arbiter sharing one single-port DRAM among NUM_CORES cores.
// Each access runs IDLE -> ISSUE -> (WAIT) -> RESP; waiting cores are stalled via core_status.
module dram_arbiter_mc #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_rd_req,
  input  logic [NUM_CORES-1:0]        core_wr_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_end_process,
  output logic [NUM_CORES-1:0]        core_status,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic [DATA_W-1:0]           dram_wdata,
  output logic                        dram_wr_en,
  output logic                        dram_rd_en,
  input  logic [DATA_W-1:0]           dram_rdata,
  output logic                        all_done
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       grant, grant_n;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_n;
  logic                   op_wr, op_wr_n;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_n;
  logic [NUM_CORES-1:0]   just_acked, just_acked_n;
  logic [NUM_CORES-1:0]   end_flag, end_flag_n;
  logic [NUM_CORES-1:0]   eligible;
  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic [NUM_CORES-1:0]   status_n, rvalid_n;
  logic [DATA_W-1:0]      rdata_n;
  logic [ADDR_W-1:0]      dram_addr_n;
  logic [DATA_W-1:0]      dram_wdata_n;
  logic                   wr_en_n, rd_en_n, all_done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= IDX_W'(NUM_CORES - 1);
      op_wr       <= 1'b0;
      wait_cnt    <= '0;
      just_acked  <= '0;
      end_flag    <= '0;
      core_status <= '1;
      core_rvalid <= '0;
      core_rdata  <= '0;
      dram_addr   <= '0;
      dram_wdata  <= '0;
      dram_wr_en  <= 1'b0;
      dram_rd_en  <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      rr_ptr      <= rr_ptr_n;
      op_wr       <= op_wr_n;
      wait_cnt    <= wait_cnt_n;
      just_acked  <= just_acked_n;
      end_flag    <= end_flag_n;
      core_status <= status_n;
      core_rvalid <= rvalid_n;
      core_rdata  <= rdata_n;
      dram_addr   <= dram_addr_n;
      dram_wdata  <= dram_wdata_n;
      dram_wr_en  <= wr_en_n;
      dram_rd_en  <= rd_en_n;
      all_done    <= all_done_n;
    end
  end

  always_comb begin
    eligible     = (core_rd_req | core_wr_req) & ~end_flag & ~just_acked;
    found        = 1'b0;
    pick         = '0;
    state_n      = state;
    grant_n      = grant;
    rr_ptr_n     = rr_ptr;
    op_wr_n      = op_wr;
    wait_cnt_n   = wait_cnt;
    just_acked_n = '0;
    end_flag_n   = end_flag | core_end_process;
    status_n     = '1;
    rvalid_n     = '0;
    rdata_n      = core_rdata;
    dram_addr_n  = dram_addr;
    dram_wdata_n = dram_wdata;
    wr_en_n      = 1'b0;
    rd_en_n      = 1'b0;
    all_done_n   = all_done | (&end_flag);

    // Search starts one past the last grant so the previous winner goes last.
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!found && eligible[(int'(rr_ptr) + k) % NUM_CORES]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_n      = ISSUE;
          grant_n      = pick;
          rr_ptr_n     = pick;
          op_wr_n      = core_wr_req[pick];
          dram_addr_n  = core_addr[int'(pick)*ADDR_W +: ADDR_W];
          dram_wdata_n = core_wdata[int'(pick)*DATA_W +: DATA_W];
          wr_en_n      = core_wr_req[pick];
          rd_en_n      = ~core_wr_req[pick];
        end
      end
      ISSUE: begin
        if (op_wr) begin
          state_n         = RESP;
          rvalid_n[grant] = 1'b1;
        end else begin
          state_n    = WAIT;
          wait_cnt_n = '0;
        end
      end
      WAIT: begin
        if (wait_cnt == CNT_W'(RD_LATENCY - 1)) begin
          state_n         = RESP;
          rvalid_n[grant] = 1'b1;
          rdata_n         = dram_rdata;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_n             = IDLE;
        just_acked_n[grant] = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // The served core is released on entry to RESP and stays released for the
    // following IDLE cycle, while its still-held request is masked.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (state_n == RESP && grant_n == IDX_W'(i))
        status_n[i] = 1'b1;
      else if ((state_n == ISSUE || state_n == WAIT) && grant_n == IDX_W'(i))
        status_n[i] = 1'b0;
      else if (state == RESP && grant == IDX_W'(i))
        status_n[i] = 1'b1;
      else
        status_n[i] = ~eligible[i];
    end
  end

endmodule

// File: tb/tb_dram_arbiter_mc.sv
// Directed testbench for dram_arbiter_mc: reset, single write/read, round-robin
// fairness, reset during a read, and end_process / all_done tracking.
module tb_dram_arbiter_mc;

  localparam int NUM_CORES  = 4;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int RD_LATENCY = 1;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_CORES-1:0]        core_rd_req;
  logic [NUM_CORES-1:0]        core_wr_req;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_end_process;
  logic [NUM_CORES-1:0]        core_status;
  logic [NUM_CORES-1:0]        core_rvalid;
  logic [DATA_W-1:0]           core_rdata;
  logic [ADDR_W-1:0]           dram_addr;
  logic [DATA_W-1:0]           dram_wdata;
  logic                        dram_wr_en;
  logic                        dram_rd_en;
  logic [DATA_W-1:0]           dram_rdata;
  logic                        all_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dram_arbiter_mc #(
    .NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .core_rd_req(core_rd_req), .core_wr_req(core_wr_req),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_end_process(core_end_process),
    .core_status(core_status), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_wr_en(dram_wr_en), .dram_rd_en(dram_rd_en),
    .dram_rdata(dram_rdata), .all_done(all_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] endp);
    core_rd_req      = rd;
    core_wr_req      = wr;
    core_end_process = endp;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    core_addr  = '0;
    core_wdata = '0;
    dram_rdata = '0;
    applyStimulus(4'b1111, 4'b0000, 4'b0000);

    // Reset held two cycles with requests high
    tick();
    tick();
    checkOutput("rst_rd_en", dram_rd_en, 0);
    checkOutput("rst_wr_en", dram_wr_en, 0);
    checkOutput("rst_status", core_status, 4'b1111);
    checkOutput("rst_rvalid", core_rvalid, 0);
    checkOutput("rst_all_done", all_done, 0);
    checkOutput("rst_rdata", core_rdata, 0);
    checkOutput("rst_dram_addr", dram_addr, 0);

    // Core 0 writes 0x23 to 0x0010
    rst = 1'b0;
    applyStimulus(4'b0000, 4'b0001, 4'b0000);
    core_addr[0*ADDR_W +: ADDR_W]  = 16'h0010;
    core_wdata[0*DATA_W +: DATA_W] = 8'h23;
    tick();
    checkOutput("wr_issue_wr_en", dram_wr_en, 1);
    checkOutput("wr_issue_rd_en", dram_rd_en, 0);
    checkOutput("wr_issue_addr", dram_addr, 16'h0010);
    checkOutput("wr_issue_wdata", dram_wdata, 8'h23);
    checkOutput("wr_issue_status", core_status, 4'b1110);
    checkOutput("wr_issue_rvalid", core_rvalid, 0);
    tick();
    checkOutput("wr_resp_rvalid", core_rvalid, 4'b0001);
    checkOutput("wr_resp_wr_en", dram_wr_en, 0);
    checkOutput("wr_resp_status", core_status, 4'b1111);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("wr_idle_rvalid", core_rvalid, 0);
    checkOutput("wr_idle_rdata", core_rdata, 0);

    // Core 2 reads 0x0005, DRAM returns 35
    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    core_addr[2*ADDR_W +: ADDR_W] = 16'h0005;
    dram_rdata = 8'd35;
    tick();
    checkOutput("rd_issue_rd_en", dram_rd_en, 1);
    checkOutput("rd_issue_addr", dram_addr, 16'h0005);
    checkOutput("rd_issue_status", core_status, 4'b1011);
    tick();
    checkOutput("rd_wait_rd_en", dram_rd_en, 0);
    checkOutput("rd_wait_status", core_status, 4'b1011);
    checkOutput("rd_wait_rvalid", core_rvalid, 0);
    tick();
    checkOutput("rd_resp_rvalid", core_rvalid, 4'b0100);
    checkOutput("rd_resp_rdata", core_rdata, 8'd35);
    checkOutput("rd_resp_status", core_status, 4'b1111);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("rd_idle_rvalid", core_rvalid, 0);

    // Fresh reset, then all four cores write continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_addr[i*ADDR_W +: ADDR_W]  = 16'h0100 + 16'(i);
      core_wdata[i*DATA_W +: DATA_W] = 8'h40 + 8'(i);
    end
    applyStimulus(4'b0000, 4'b1111, 4'b0000);
    for (int n = 0; n < 6; n++) begin
      int expc;
      expc = n % 4;
      tick();
      checkOutput($sformatf("rr%0d_wr_en", n), dram_wr_en, 1);
      checkOutput($sformatf("rr%0d_addr", n), dram_addr, 32'h0100 + 32'(expc));
      checkOutput($sformatf("rr%0d_wdata", n), dram_wdata, 32'h40 + 32'(expc));
      if (n == 0) checkOutput("rr0_issue_status", core_status, 4'b0000);
      tick();
      checkOutput($sformatf("rr%0d_rvalid", n), core_rvalid, 32'(1) << expc);
      checkOutput($sformatf("rr%0d_resp_status", n), core_status, 32'(1) << expc);
      tick();
      checkOutput($sformatf("rr%0d_idle_rvalid", n), core_rvalid, 0);
      checkOutput($sformatf("rr%0d_idle_status", n), core_status, 32'(1) << expc);
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();

    // Core 1 reads alone, reset lands in its WAIT cycle
    core_addr[0*ADDR_W +: ADDR_W] = 16'h0AA0;
    core_addr[1*ADDR_W +: ADDR_W] = 16'h0BB1;
    dram_rdata = 8'h5A;
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    tick();
    checkOutput("c1_issue_addr", dram_addr, 16'h0BB1);
    checkOutput("c1_issue_rd_en", dram_rd_en, 1);
    tick();
    rst = 1'b1;
    applyStimulus(4'b0011, 4'b0000, 4'b0000);
    tick();
    checkOutput("midrst_rd_en", dram_rd_en, 0);
    checkOutput("midrst_rvalid", core_rvalid, 0);
    checkOutput("midrst_status", core_status, 4'b1111);
    checkOutput("midrst_rdata", core_rdata, 0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_grant_addr", dram_addr, 16'h0AA0);
    checkOutput("post_rst_rd_en", dram_rd_en, 1);
    checkOutput("post_rst_status", core_status, 4'b1100);
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    tick();
    checkOutput("post_rst_wait_status", core_status, 4'b1110);
    tick();
    checkOutput("post_rst_rvalid", core_rvalid, 4'b0001);
    checkOutput("post_rst_rdata", core_rdata, 8'h5A);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();

    // Cores finish one by one; requests from finished cores are ignored
    applyStimulus(4'b0000, 4'b0000, 4'b0001);
    tick();
    applyStimulus(4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("end0_wr_en", dram_wr_en, 0);
    checkOutput("end0_status", core_status, 4'b1111);
    checkOutput("end0_all_done", all_done, 0);
    applyStimulus(4'b0000, 4'b0011, 4'b0100);
    tick();
    checkOutput("end1_wr_en", dram_wr_en, 0);
    checkOutput("end1_status", core_status, 4'b1111);
    applyStimulus(4'b0111, 4'b0000, 4'b1000);
    tick();
    checkOutput("end2_rd_en", dram_rd_en, 0);
    checkOutput("end2_status", core_status, 4'b1111);
    checkOutput("end3_all_done_early", all_done, 0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    tick();
    checkOutput("all_done_rise", all_done, 1);
    tick();
    checkOutput("all_done_hold", all_done, 1);
    checkOutput("done_rd_en", dram_rd_en, 0);
    checkOutput("done_status", core_status, 4'b1111);
    tick();
    checkOutput("done_rvalid", core_rvalid, 0);
    checkOutput("all_done_hold2", all_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
